// File: rtl/ws2812_pkg.sv
// ws2812_pkg: constants, default timing counts and FSM state type shared
// by the WS2812 frame receiver and its pulse meter.
package ws2812_pkg;

    localparam int BITS_PER_LED        = 24;
    localparam int DEF_NUM_LEDS        = 8;
    localparam int DEF_BIT_THRESHOLD   = 15;
    localparam int DEF_MIN_HIGH_CYCLES = 3;
    localparam int DEF_MAX_HIGH_CYCLES = 40;
    localparam int DEF_RESET_CYCLES    = 1250;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } rx_state_t;

    // Width of the saturating high/low counters.
    function automatic int cnt_width(input int reset_cycles);
        return $clog2(reset_cycles + 1);
    endfunction

endpackage

// File: rtl/ws2812_pulse_meter.sv
// ws2812_pulse_meter: synchronizes din, detects edges and measures the
// current high and low run lengths in clk cycles.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   din         : raw serial line (asynchronous)
//   rise, fall  : one-cycle registered edge pulses
//   level       : line level aligned with the counters and edge pulses
//   high_cnt    : length of the current/last high run (saturating)
//   low_cnt     : length of the current/last low run (saturating)
module ws2812_pulse_meter
    import ws2812_pkg::*;
#(
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int CNT_W        = cnt_width(RESET_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             rise,
    output logic             fall,
    output logic             level,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic s1;
    logic s2;
    logic prev;

    // Each counter restarts at 1 on its own run's first cycle and holds
    // its value through the opposite run, so high_cnt is the full pulse
    // width in the cycle the fall pulse is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            prev     <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            high_cnt <= '0;
            low_cnt  <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
            rise <= s2 & ~prev;
            fall <= ~s2 & prev;

            if (s2 && !prev) begin
                high_cnt <= ONE;
            end else if (s2 && high_cnt != SAT) begin
                high_cnt <= high_cnt + ONE;
            end

            if (!s2 && prev) begin
                low_cnt <= ONE;
            end else if (!s2 && low_cnt != SAT) begin
                low_cnt <= low_cnt + ONE;
            end
        end
    end

    assign level = prev;

endmodule

// File: rtl/ws2812_frame_receiver.sv
// ws2812_frame_receiver: decodes a WS2812 pulse-width stream into 24-bit
// frames and publishes a complete set atomically on each line-reset gap.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   din           : serial line (asynchronous)
//   frames_out    : latched set, LEDn in [24n+23:24n]
//   frames_valid  : one-cycle pulse when frames_out updates
//   frames_count  : complete frames in the last set (saturates)
//   overflow      : with frames_valid, more frames than slots arrived
//   bit_valid     : one-cycle pulse per decoded bit, value on bit_value
//   error         : one-cycle pulse on glitch, long high or partial frame
module ws2812_frame_receiver
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS        = DEF_NUM_LEDS,
    parameter int BIT_THRESHOLD   = DEF_BIT_THRESHOLD,
    parameter int MIN_HIGH_CYCLES = DEF_MIN_HIGH_CYCLES,
    parameter int MAX_HIGH_CYCLES = DEF_MAX_HIGH_CYCLES,
    parameter int RESET_CYCLES    = DEF_RESET_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             din,
    output logic [NUM_LEDS*BITS_PER_LED-1:0] frames_out,
    output logic                             frames_valid,
    output logic [3:0]                       frames_count,
    output logic                             overflow,
    output logic                             bit_valid,
    output logic                             bit_value,
    output logic                             error
);

    localparam int CW = cnt_width(RESET_CYCLES);
    localparam int FW = $clog2(NUM_LEDS + 1);
    localparam int FB = NUM_LEDS * BITS_PER_LED;

    localparam logic [CW-1:0] RESET_CNT = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] THR_CNT   = CW'(BIT_THRESHOLD);
    localparam logic [CW-1:0] MIN_CNT   = CW'(MIN_HIGH_CYCLES);
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_HIGH_CYCLES);
    localparam logic [FW-1:0] LED_CNT   = FW'(NUM_LEDS);
    localparam logic [4:0]    LAST_BIT  = 5'(BITS_PER_LED - 1);

    logic          rise;
    logic          fall;
    logic          level;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] low_cnt;

    ws2812_pulse_meter #(
        .RESET_CYCLES (RESET_CYCLES),
        .CNT_W        (CW)
    ) u_meter (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rise     (rise),
        .fall     (fall),
        .level    (level),
        .high_cnt (high_cnt),
        .low_cnt  (low_cnt)
    );

    rx_state_t               state;
    logic [BITS_PER_LED-1:0] shift_reg;
    logic [4:0]              bit_idx;
    logic [FW-1:0]           frame_idx;
    logic                    ovf_flag;
    logic [FB-1:0]           work_buf;

    logic                    bit_now;
    logic [BITS_PER_LED-1:0] next_frame;
    logic                    gap;

    assign bit_now    = (high_cnt >= THR_CNT);
    assign next_frame = {shift_reg[BITS_PER_LED-2:0], bit_now};
    assign gap        = (low_cnt == RESET_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SYNC;
            shift_reg    <= '0;
            bit_idx      <= '0;
            frame_idx    <= '0;
            ovf_flag     <= 1'b0;
            work_buf     <= '0;
            frames_out   <= '0;
            frames_valid <= 1'b0;
            frames_count <= '0;
            overflow     <= 1'b0;
            bit_valid    <= 1'b0;
            bit_value    <= 1'b0;
            error        <= 1'b0;
        end else begin
            frames_valid <= 1'b0;
            overflow     <= 1'b0;
            bit_valid    <= 1'b0;
            error        <= 1'b0;

            unique case (state)
                SYNC: begin
                    // Only a low run of the full gap length synchronizes.
                    if (!level && gap) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                    end
                end

                LOW: begin
                    if (gap) begin
                        if (bit_idx != '0) begin
                            error <= 1'b1;
                        end else if (frame_idx != '0) begin
                            frames_out   <= work_buf;
                            frames_count <= 4'(frame_idx);
                            overflow     <= ovf_flag;
                            frames_valid <= 1'b1;
                        end
                        shift_reg <= '0;
                        bit_idx   <= '0;
                        frame_idx <= '0;
                        ovf_flag  <= 1'b0;
                        work_buf  <= '0;
                        // A rise coinciding with the gap starts the next set.
                        state     <= rise ? HIGH : IDLE;
                    end else if (rise) begin
                        state <= HIGH;
                    end
                end

                HIGH: begin
                    if (high_cnt > MAX_CNT) begin
                        error     <= 1'b1;
                        shift_reg <= '0;
                        bit_idx   <= '0;
                        frame_idx <= '0;
                        ovf_flag  <= 1'b0;
                        work_buf  <= '0;
                        state     <= SYNC;
                    end else if (fall) begin
                        state <= LOW;
                        if (high_cnt < MIN_CNT) begin
                            error <= 1'b1;
                        end else begin
                            bit_valid <= 1'b1;
                            bit_value <= bit_now;
                            shift_reg <= next_frame;
                            if (bit_idx == LAST_BIT) begin
                                bit_idx <= '0;
                                if (frame_idx < LED_CNT) begin
                                    for (int i = 0; i < NUM_LEDS; i++) begin
                                        if (frame_idx == FW'(i)) begin
                                            work_buf[i*BITS_PER_LED +: BITS_PER_LED]
                                                <= next_frame;
                                        end
                                    end
                                    frame_idx <= frame_idx + FW'(1);
                                end else begin
                                    ovf_flag <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 5'd1;
                            end
                        end
                    end
                end

                default: state <= SYNC;
            endcase
        end
    end

endmodule
